// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port plus the fetch/decode handoff.
// The master modport is the fetch unit's view; slave is the memory/decode side.
interface fetch_unit_if #(
    parameter int COUNT_W = 16
);
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic [31:0]        i_fetch;
    logic [31:0]        pc;
    logic               i_valid;
    logic               i_ready;
    logic [31:0]        next_pc;
    logic [COUNT_W-1:0] fetch_count;
    logic               fetch_fault;

    modport master (
        output imem_req, imem_addr, i_fetch, pc, i_valid, fetch_count, fetch_fault,
        input  imem_ack, imem_rdata, i_ready, next_pc
    );

    modport slave (
        input  imem_req, imem_addr, i_fetch, pc, i_valid, fetch_count, fetch_fault,
        output imem_ack, imem_rdata, i_ready, next_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: one word in flight, PC owned here, next PC from decode.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned next_pc into a sticky fault state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t             state, state_next;
    logic [31:0]        pc_q;
    logic [31:0]        fetch_q;
    logic [COUNT_W-1:0] count_q;
    logic               consume;
    logic               capture;
    logic               misaligned;
    logic [31:0]        pc_new;

    assign capture = (state == S_WAIT) && bus.imem_ack;
    assign consume = (state == S_HOLD) && bus.i_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (bus.next_pc[1:0] != 2'b00);
    assign pc_new     = bus.next_pc;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^bus.next_pc[1:0];
    assign misaligned      = 1'b0;
    assign pc_new          = {bus.next_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_WAIT;
            S_WAIT:  if (capture) state_next = S_HOLD;
            S_HOLD:  if (consume) state_next = misaligned ? S_FAULT : S_WAIT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fetch_q <= '0;
            count_q <= '0;
        end else begin
            if (capture) begin
                fetch_q <= bus.imem_rdata;
            end
            if (consume) begin
                pc_q    <= pc_new;
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    // Request/valid decode from state only, so reset drops imem_req asynchronously.
    assign bus.imem_req    = (state == S_WAIT);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.i_fetch     = fetch_q;
    assign bus.i_valid     = (state == S_HOLD);
    assign bus.fetch_count = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = (state == S_FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch/consume, memory wait, decode stall,
// branch, mid-request reset with stale ack, and misaligned next_pc handling.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    fetch_unit_if #(.COUNT_W(16)) bus ();

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .COUNT_W (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.i_ready    = 1'b0;
        bus.next_pc    = 32'h0;
        step();
        step();
        check("rst_req",   {31'b0, bus.imem_req},    32'h0);
        check("rst_valid", {31'b0, bus.i_valid},     32'h0);
        check("rst_pc",    bus.pc,                   32'h0);
        check("rst_fetch", bus.i_fetch,              32'h0);
        check("rst_count", {16'b0, bus.fetch_count}, 32'h0);
        check("rst_fault", {31'b0, bus.fetch_fault}, 32'h0);

        // Release: first edge IDLE->WAIT, request visible after it.
        reset = 1'b0;
        step();
        check("first_req",  {31'b0, bus.imem_req}, 32'h1);
        check("first_addr", bus.imem_addr,         32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1111_0000;
        step();
        check("cap0_valid", {31'b0, bus.i_valid},  32'h1);
        check("cap0_fetch", bus.i_fetch,           32'h1111_0000);
        check("cap0_req",   {31'b0, bus.imem_req}, 32'h0);
        check("cap0_pc",    bus.pc,                32'h0);
        bus.imem_ack = 1'b0;
        bus.i_ready  = 1'b1;
        bus.next_pc  = 32'h4;
        step();
        check("seq_req",   {31'b0, bus.imem_req},    32'h1);
        check("seq_addr",  bus.imem_addr,            32'h4);
        check("seq_valid", {31'b0, bus.i_valid},     32'h0);
        check("seq_count", {16'b0, bus.fetch_count}, 32'h1);

        // Memory waits three cycles.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req",   {31'b0, bus.imem_req}, 32'h1);
            check("wait_addr",  bus.imem_addr,         32'h4);
            check("wait_valid", {31'b0, bus.i_valid},  32'h0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2222_0004;
        step();
        check("cap1_valid", {31'b0, bus.i_valid}, 32'h1);
        check("cap1_fetch", bus.i_fetch,          32'h2222_0004);
        check("cap1_pc",    bus.pc,               32'h4);

        // Decode stall; a stray ack in HOLD must not overwrite i_fetch.
        bus.imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'b0, bus.i_valid},     32'h1);
            check("stall_fetch", bus.i_fetch,              32'h2222_0004);
            check("stall_pc",    bus.pc,                   32'h4);
            check("stall_req",   {31'b0, bus.imem_req},    32'h0);
            check("stall_count", {16'b0, bus.fetch_count}, 32'h1);
        end

        // Branch to 0x100.
        bus.imem_ack = 1'b0;
        bus.i_ready  = 1'b1;
        bus.next_pc  = 32'h100;
        step();
        check("br_req",   {31'b0, bus.imem_req},    32'h1);
        check("br_addr",  bus.imem_addr,            32'h100);
        check("br_count", {16'b0, bus.fetch_count}, 32'h2);
        bus.i_ready    = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h3333_0100;
        step();
        check("br_valid", {31'b0, bus.i_valid}, 32'h1);
        check("br_pc",    bus.pc,               32'h100);
        check("br_fetch", bus.i_fetch,          32'h3333_0100);

        // Reach WAIT at 0x40, then reset mid-request.
        bus.imem_ack = 1'b0;
        bus.i_ready  = 1'b1;
        bus.next_pc  = 32'h40;
        step();
        check("w40_addr",  bus.imem_addr,            32'h40);
        check("w40_count", {16'b0, bus.fetch_count}, 32'h3);
        bus.i_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req",   {31'b0, bus.imem_req},    32'h0);
        check("arst_pc",    bus.pc,                   32'h0);
        check("arst_count", {16'b0, bus.fetch_count}, 32'h0);
        step();
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        check("stale_valid", {31'b0, bus.i_valid},  32'h0);
        check("stale_fetch", bus.i_fetch,           32'h0);
        check("restart_req", {31'b0, bus.imem_req}, 32'h1);
        check("restart_addr", bus.imem_addr,        32'h0);
        bus.imem_rdata = 32'h4444_0000;
        step();
        check("re_valid", {31'b0, bus.i_valid}, 32'h1);
        check("re_fetch", bus.i_fetch,          32'h4444_0000);

        // Misaligned next_pc.
        bus.imem_ack = 1'b0;
        bus.i_ready  = 1'b1;
        bus.next_pc  = 32'h102;
        step();
        check("mis_count", {16'b0, bus.fetch_count}, 32'h1);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, bus.fetch_fault}, 32'h1);
        check("mis_req",   {31'b0, bus.imem_req},    32'h0);
        check("mis_valid", {31'b0, bus.i_valid},     32'h0);
        check("mis_pc",    bus.pc,                   32'h102);
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flt_fault", {31'b0, bus.fetch_fault}, 32'h1);
            check("flt_req",   {31'b0, bus.imem_req},    32'h0);
            check("flt_count", {16'b0, bus.fetch_count}, 32'h1);
        end
`else
        check("mis_fault", {31'b0, bus.fetch_fault}, 32'h0);
        check("mis_req",   {31'b0, bus.imem_req},    32'h1);
        check("mis_addr",  bus.imem_addr,            32'h100);
        bus.i_ready    = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h5555_0100;
        step();
        check("mis_valid",  {31'b0, bus.i_valid},     32'h1);
        check("mis_pc",     bus.pc,                   32'h100);
        check("mis_fetch",  bus.i_fetch,              32'h5555_0100);
        check("mis_fault2", {31'b0, bus.fetch_fault}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
